atm_keypad_frontend: RTL
========================

# atm_keypad_frontend

Keypad entry sequencer on the user side of the ATM core. Collects decimal keystrokes and assembles account number, PIN, menu option, amount and destination account, then presents them as one validated request to the ATM core using a valid/ready handshake. It also enforces an inactivity timeout on the entry session. Sits between the physical keypad scanner and the ATM transaction core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 128: idle cycles without a keystroke (non-IDLE, non-ISSUE) before the session is abandoned
- ACC_MAX, 4095: largest legal account number (12 bits)
- AMT_MAX, 2047: largest legal amount (11 bits)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD-0xF ignored
- req_ready  in  1  ATM core accepts request
- req_valid  out  1  request pending; fields stable while high
- acc_number  out  12  assembled account number
- pin  out  4  PIN digit 0-9
- menu_option  out  3  menu code
- amount  out  11  amount
- dest_acc  out  12  destination account (TRANSACTION only, else 0)
- key_err  out  1  one-cycle pulse on a rejected key
- timeout  out  1  one-cycle pulse on session timeout

## Operation
- States: IDLE, ACC, PIN, MENU, DEST, AMT, ISSUE.
- Digit accumulation: next = value*10 + digit, computed 14 bits wide. Reject (key_err, value unchanged) if digit count is already 4 or next exceeds the field limit (ACC_MAX for ACC/DEST, AMT_MAX for AMT).
- IDLE: a digit loads acc_number and moves to ACC. ENTER/CLEAR ignored silently.
- ACC: digits accumulate. ENTER with at least 1 digit moves to PIN. ENTER with 0 digits gives key_err.
- PIN: a digit overwrites pin (single digit). ENTER after at least 1 digit moves to MENU, otherwise key_err.
- MENU: digit 3-7 overwrites menu_option. Digit 0-2 or 8-9 gives key_err. ENTER then routes by code:
  - 3 (BALANCE) goes to ISSUE.
  - 4, 5, 7 go to AMT.
  - 6 (TRANSACTION) goes to DEST.
  - ENTER with no menu digit gives key_err.
- DEST: accumulate, then ENTER (at least 1 digit) moves to AMT.
- AMT: accumulate, then ENTER (at least 1 digit) moves to ISSUE.
- ISSUE: req_valid=1 and all keys are ignored. On req_valid&&req_ready: return to MENU; clear amount, dest_acc, menu_option and the menu-digit flag; keep acc_number and pin.
- CLEAR (non-IDLE, non-ISSUE): zeroes the current field and its digit count. State is unchanged.
- CANCEL (non-ISSUE): go to IDLE and zero all fields.
- Timer: reloaded on any key_valid; counts in ACC..AMT; frozen in IDLE/ISSUE. On expiry: timeout pulse, go to IDLE, zero all fields.

## Timing
- Reset values: all outputs 0, state IDLE, timer 0, digit counts 0.
- A key sampled at edge N is reflected in fields/state after edge N. key_err is high for the cycle after edge N.
- req_valid rises the cycle after the accepted ENTER. It falls the cycle after the handshake edge. Back-to-back requests are impossible (at least one MENU entry in between).
- key_valid on the same edge the timer would expire: the key wins, the timer reloads, no timeout.
- Expiry fires after exactly TIMEOUT_CYCLES edges with no key.
- Reset mid-ISSUE: req_valid drops asynchronously. No request is delivered.

## Structure
- Shared package atm_pkg holds: menu codes (WAITING 0, MENU 2, BALANCE 3, WITHDRAW 4, WITHDRAW_SHOW_BALANCE 5, TRANSACTION 6, DEPOSIT 7), key_code constants, and the frontend state enum. The ATM core uses the same menu codes.
- One sub-module, atm_bcd_accumulator (inputs: digit, load, clear, limit; outputs: value, count, reject), instanced once. It is muxed onto the active field.

## Test plan
- Keys 4,0,2,3,ENTER,0,ENTER,3,ENTER → req_valid with acc_number=4023, pin=0, menu_option=3; hold req_ready low 5 cycles, then high → fields stable throughout, state MENU after handshake.
- Session as above, then 6,ENTER,1,3,9,2,ENTER,2,0,0,ENTER → menu_option=6, dest_acc=1392, amount=200.
- In AMT, keys 2,0,4,8 → last digit gives key_err, amount=204; CLEAR → amount=0.
- ACC digits 4,0,9,6 → key_err on 6, acc_number=409; then 5 → 4095.
- In PIN, no key for 128 cycles → timeout pulse at cycle 128, IDLE, all outputs 0; repeat with a key at cycle 127 → no timeout.
- Assert rst_n low during ISSUE → req_valid 0 immediately; CANCEL during ISSUE → ignored, request still delivered.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad frontend and the ATM transaction core:
// menu codes, keypad codes and the frontend state encoding.
package atm_pkg;

    // Menu codes, shared with the ATM core
    localparam logic [2:0] MENU_WAITING               = 3'd0;
    localparam logic [2:0] MENU_MENU                  = 3'd2;
    localparam logic [2:0] MENU_BALANCE               = 3'd3;
    localparam logic [2:0] MENU_WITHDRAW              = 3'd4;
    localparam logic [2:0] MENU_WITHDRAW_SHOW_BALANCE = 3'd5;
    localparam logic [2:0] MENU_TRANSACTION           = 3'd6;
    localparam logic [2:0] MENU_DEPOSIT               = 3'd7;

    // Keypad codes; 0-9 are digits, 0xD-0xF are ignored
    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_PIN,
        ST_MENU,
        ST_DEST,
        ST_AMT,
        ST_ISSUE
    } fe_state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_keypad_frontend_if.sv
// Keypad-side inputs and the request bundle presented to the ATM core.
// The frontend uses the master view; the core/keypad side uses the slave view.
interface atm_keypad_frontend_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        req_ready;
    logic        req_valid;
    logic [11:0] acc_number;
    logic [3:0]  pin;
    logic [2:0]  menu_option;
    logic [10:0] amount;
    logic [11:0] dest_acc;
    logic        key_err;
    logic        timeout;

    modport master (
        input  key_valid, key_code, req_ready,
        output req_valid, acc_number, pin, menu_option, amount, dest_acc,
               key_err, timeout
    );

    modport slave (
        output key_valid, key_code, req_ready,
        input  req_valid, acc_number, pin, menu_option, amount, dest_acc,
               key_err, timeout
    );
endinterface

// File: rtl/atm_bcd_accumulator.sv
// Decimal field accumulator: value*10 + digit with a digit-count cap of 4 and
// an upper limit. Purely combinational; the caller muxes the active field in
// and writes the result back into that field's register.
module atm_bcd_accumulator (
    input  logic [11:0] cur_value_i,
    input  logic [2:0]  cur_count_i,
    input  logic [3:0]  digit_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [11:0] limit_i,
    output logic [11:0] value_o,
    output logic [2:0]  count_o,
    output logic        reject_o
);

    logic [13:0] next_val;

    // Next value and accept/reject decision; a rejected digit leaves the field unchanged
    always_comb begin
        next_val = ({2'b00, cur_value_i} * 14'd10) + {10'd0, digit_i};
        value_o  = cur_value_i;
        count_o  = cur_count_i;
        reject_o = 1'b0;
        if (clear_i) begin
            value_o = 12'd0;
            count_o = 3'd0;
        end else if (load_i) begin
            if ((cur_count_i >= 3'd4) || (next_val > {2'b00, limit_i})) begin
                reject_o = 1'b1;
            end else begin
                value_o = next_val[11:0];
                count_o = cur_count_i + 3'd1;
            end
        end
    end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad entry sequencer: assembles account, PIN, menu option, destination and
// amount from keystrokes and issues one request to the ATM core with a
// valid/ready handshake. Abandons the session after an inactivity timeout.
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 128,
    parameter int ACC_MAX        = 4095,
    parameter int AMT_MAX        = 2047
) (
    input  logic                 clk,
    input  logic                 rst_n,
    atm_keypad_frontend_if.master bus
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    fe_state_e       state_q, state_d;
    logic [11:0]     acc_q, acc_d;
    logic [3:0]      pin_q, pin_d;
    logic [2:0]      menu_q, menu_d;
    logic [10:0]     amt_q, amt_d;
    logic [11:0]     dest_q, dest_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            key_err_q, key_err_d;
    logic            timeout_q, timeout_d;

    logic [11:0]     acc_cur, acc_limit, acc_val;
    logic [2:0]      acc_cnt;
    logic            acc_rej, acc_load, acc_clear;

    assign acc_load  = bus.key_valid && is_digit(bus.key_code);
    assign acc_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);

    // Route the field being typed, and its limit, into the shared accumulator
    always_comb begin
        acc_cur   = 12'd0;
        acc_limit = 12'(ACC_MAX);
        case (state_q)
            ST_ACC:  acc_cur = acc_q;
            ST_DEST: acc_cur = dest_q;
            ST_AMT: begin
                acc_cur   = {1'b0, amt_q};
                acc_limit = 12'(AMT_MAX);
            end
            default: ;
        endcase
    end

    atm_bcd_accumulator u_acc (
        .cur_value_i (acc_cur),
        .cur_count_i (cnt_q),
        .digit_i     (bus.key_code),
        .load_i      (acc_load),
        .clear_i     (acc_clear),
        .limit_i     (acc_limit),
        .value_o     (acc_val),
        .count_o     (acc_cnt),
        .reject_o    (acc_rej)
    );

    // Next-state, field updates, inactivity timer and pulse outputs
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        pin_d     = pin_q;
        menu_d    = menu_q;
        amt_d     = amt_q;
        dest_d    = dest_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        key_err_d = 1'b0;
        timeout_d = 1'b0;

        // A key always reloads; the timer only runs while a field is being entered
        if (bus.key_valid) begin
            tmr_d = '0;
        end else if ((state_q != ST_IDLE) && (state_q != ST_ISSUE)) begin
            if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmr_d     = '0;
                timeout_d = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end

        if (timeout_d) begin
            state_d = ST_IDLE;
            acc_d = '0; pin_d = '0; menu_d = '0; amt_d = '0; dest_d = '0; cnt_d = '0;
        end else if (state_q == ST_ISSUE) begin
            // Keys are ignored here; the session continues at MENU after delivery
            if (bus.req_ready) begin
                state_d = ST_MENU;
                menu_d  = '0;
                amt_d   = '0;
                dest_d  = '0;
                cnt_d   = '0;
            end
        end else if (bus.key_valid) begin
            if (bus.key_code == KEY_CANCEL) begin
                state_d = ST_IDLE;
                acc_d = '0; pin_d = '0; menu_d = '0; amt_d = '0; dest_d = '0; cnt_d = '0;
            end else if (bus.key_code == KEY_CLEAR) begin
                case (state_q)
                    ST_ACC:  begin acc_d  = acc_val;        cnt_d = acc_cnt; end
                    ST_DEST: begin dest_d = acc_val;        cnt_d = acc_cnt; end
                    ST_AMT:  begin amt_d  = acc_val[10:0];  cnt_d = acc_cnt; end
                    ST_PIN:  begin pin_d  = '0;             cnt_d = '0;      end
                    ST_MENU: begin menu_d = '0;             cnt_d = '0;      end
                    default: ;
                endcase
            end else if (bus.key_code == KEY_ENTER) begin
                if (state_q != ST_IDLE) begin
                    if (cnt_q == 3'd0) begin
                        key_err_d = 1'b1;
                    end else begin
                        cnt_d = '0;
                        case (state_q)
                            ST_ACC:  state_d = ST_PIN;
                            ST_PIN:  state_d = ST_MENU;
                            ST_DEST: state_d = ST_AMT;
                            ST_AMT:  state_d = ST_ISSUE;
                            ST_MENU: begin
                                case (menu_q)
                                    MENU_BALANCE:     state_d = ST_ISSUE;
                                    MENU_TRANSACTION: state_d = ST_DEST;
                                    MENU_WITHDRAW, MENU_WITHDRAW_SHOW_BALANCE,
                                    MENU_DEPOSIT:     state_d = ST_AMT;
                                    default: begin
                                        key_err_d = 1'b1;
                                        cnt_d     = cnt_q;
                                    end
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            end else if (is_digit(bus.key_code)) begin
                case (state_q)
                    ST_IDLE: begin
                        acc_d   = acc_val;
                        cnt_d   = acc_cnt;
                        state_d = ST_ACC;
                    end
                    ST_ACC: begin
                        key_err_d = acc_rej;
                        acc_d     = acc_val;
                        cnt_d     = acc_cnt;
                    end
                    ST_DEST: begin
                        key_err_d = acc_rej;
                        dest_d    = acc_val;
                        cnt_d     = acc_cnt;
                    end
                    ST_AMT: begin
                        key_err_d = acc_rej;
                        amt_d     = acc_val[10:0];
                        cnt_d     = acc_cnt;
                    end
                    ST_PIN: begin
                        pin_d = bus.key_code;
                        cnt_d = 3'd1;
                    end
                    ST_MENU: begin
                        if ((bus.key_code >= 4'd3) && (bus.key_code <= 4'd7)) begin
                            menu_d = bus.key_code[2:0];
                            cnt_d  = 3'd1;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, field and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            pin_q     <= '0;
            menu_q    <= '0;
            amt_q     <= '0;
            dest_q    <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            key_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            pin_q     <= pin_d;
            menu_q    <= menu_d;
            amt_q     <= amt_d;
            dest_q    <= dest_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            key_err_q <= key_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.req_valid   = (state_q == ST_ISSUE);
    assign bus.acc_number  = acc_q;
    assign bus.pin         = pin_q;
    assign bus.menu_option = menu_q;
    assign bus.amount      = amt_q;
    assign bus.dest_acc    = dest_q;
    assign bus.key_err     = key_err_q;
    assign bus.timeout     = timeout_q;

endmodule
